qbus_cycle_master: RTL

Single-outstanding bus-cycle initiator for the internal QBUS device interface. It turns a command (read or write, 22-bit address, BS7, data) into the latched-address / data / write-pulse signalling that slave devices decode. It returns the slave's data, or a non-existent-memory (NXM) flag if no device claims the address within a timeout. It sits between test/DMA logic and the device modules, so devices can be exercised on-chip without an external bus master.

---
 rtl/qbus_cycle_master.sv | 128 ++++++++++++
 1 files changed

// File: rtl/qbus_cycle_master.sv
// qbus_cycle_master: single-outstanding QBUS bus-cycle initiator.
// Latches a read/write command onto RAL/RBS7/RDL, waits for a device to claim
// the address (or times out to NXM), strobes write_pulse or samples TDL, then
// holds the response until it is consumed.
module qbus_cycle_master #(
  parameter int TIMEOUT = 200
) (
  input  logic        qclk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [21:0] cmd_addr,
  input  logic        cmd_bs7,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_nxm,
  output logic [21:0] RAL,
  output logic        RBS7,
  output logic [15:0] RDL,
  output logic        write_pulse,
  input  logic        addr_match,
  input  logic [15:0] TDL
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, PULSE, READ, DONE} state_t;

  localparam logic [9:0] TLAST = 10'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [9:0] timer;
  logic       is_write;

  // Timer counts up but parks at all-ones rather than wrapping.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // State register.
  always_ff @(posedge qclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded handshake/strobe outputs.
  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    write_pulse = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid) state_nxt = ADDR;
      end
      ADDR: state_nxt = WAIT;
      WAIT: begin
        // A match on the final timer value still beats the timeout.
        if (addr_match)          state_nxt = is_write ? PULSE : READ;
        else if (timer == TLAST) state_nxt = DONE;
      end
      PULSE: begin
        write_pulse = 1'b1;
        state_nxt   = DONE;
      end
      READ: state_nxt = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus-side latches, timer and response registers.
  always_ff @(posedge qclk) begin
    if (reset) begin
      RAL       <= '0;
      RBS7      <= 1'b0;
      RDL       <= '0;
      is_write  <= 1'b0;
      timer     <= '0;
      rsp_rdata <= '0;
      rsp_nxm   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            RAL      <= cmd_addr;
            RBS7     <= cmd_bs7;
            RDL      <= cmd_write ? cmd_wdata : 16'd0;
            is_write <= cmd_write;
          end
        end
        ADDR: timer <= '0;
        WAIT: begin
          if (!addr_match) begin
            timer <= sat_inc(timer);
            if (timer == TLAST) begin
              rsp_nxm   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        PULSE: begin
          rsp_nxm   <= 1'b0;
          rsp_rdata <= '0;
        end
        READ: begin
          rsp_nxm   <= 1'b0;
          rsp_rdata <= TDL;
        end
        DONE: begin
          // RAL deliberately keeps the last address after the cycle ends.
          if (rsp_ready) begin
            RBS7 <= 1'b0;
            RDL  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
